// File: rtl/rat_intr_pkg.sv
// Shared register offsets and FSM state encoding for the RAT interrupt controller.
package rat_intr_pkg;

  localparam logic [7:0] OFS_MASK   = 8'd0;
  localparam logic [7:0] OFS_PEND   = 8'd1;
  localparam logic [7:0] OFS_ACTIVE = 8'd2;
  localparam logic [7:0] OFS_EDGE   = 8'd3;
  localparam logic [7:0] OFS_CTRL   = 8'd4;
  localparam logic [7:0] OFS_EOI    = 8'd5;
  localparam logic [7:0] N_REGS     = 8'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } intr_state_e;

endpackage

// File: rtl/rat_sync2.sv
// Single-bit two-flop synchronizer for an asynchronous interrupt line.
module rat_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Port-mapped interrupt controller: synchronizes up to 8 sources into pending bits,
// arbitrates the lowest masked-in index and drives INTR until software writes EOI.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         N_SRC   = 8,
  parameter logic [7:0] BASE_ID = 8'hE0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output logic             INTR
);

  logic [N_SRC-1:0] sync, prev, mask, pend, edge_cfg;
  logic [N_SRC-1:0] set_bits, pend_clr, masked;
  logic             gen, req;
  logic [7:0]       ofs;
  logic             wr_en, wr_mask, wr_pend, wr_edge, wr_ctrl, wr_eoi;
  logic [2:0]       win_idx;

  intr_state_e      state, state_next;
  logic             act_valid, act_valid_next;
  logic [2:0]       act_idx, act_idx_next;
  logic             intr_q, intr_next;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    rat_sync2 u_sync (
      .clk   (CLK),
      .rst_n (RESET_N),
      .d     (IRQ_IN[i]),
      .q     (sync[i])
    );
  end

  // Unsigned offset compare also rejects ports below BASE_ID via wraparound.
  assign ofs     = PORT_ID - BASE_ID;
  assign RD_HIT  = (ofs < N_REGS);
  assign wr_en   = IO_STRB && RD_HIT;
  assign wr_mask = wr_en && (ofs == OFS_MASK);
  assign wr_pend = wr_en && (ofs == OFS_PEND);
  assign wr_edge = wr_en && (ofs == OFS_EDGE);
  assign wr_ctrl = wr_en && (ofs == OFS_CTRL);
  assign wr_eoi  = wr_en && (ofs == OFS_EOI);

  assign set_bits = (sync & ~prev & edge_cfg) | (sync & ~edge_cfg);
  assign pend_clr = wr_pend ? OUT_PORT[N_SRC-1:0] : '0;
  assign masked   = pend & mask;
  assign req      = (|masked) && gen;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev     <= '0;
      mask     <= '0;
      pend     <= '0;
      edge_cfg <= '1;
      gen      <= 1'b0;
    end else begin
      prev <= sync;
      pend <= (pend & ~pend_clr) | set_bits;
      if (wr_mask) mask     <= OUT_PORT[N_SRC-1:0];
      if (wr_edge) edge_cfg <= OUT_PORT[N_SRC-1:0];
      if (wr_ctrl) gen      <= OUT_PORT[0];
    end
  end

  always_comb begin
    win_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) win_idx = 3'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      act_valid <= 1'b0;
      act_idx   <= 3'd0;
      intr_q    <= 1'b0;
    end else begin
      state     <= state_next;
      act_valid <= act_valid_next;
      act_idx   <= act_idx_next;
      intr_q    <= intr_next;
    end
  end

  // EOI outranks withdrawal so a serviced interrupt always passes through GAP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ASSERT;
      ASSERT: begin
        if (wr_eoi)    state_next = GAP;
        else if (!req) state_next = IDLE;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    act_valid_next = act_valid;
    act_idx_next   = act_idx;
    intr_next      = (state_next == ASSERT);
    if (state == IDLE && state_next == ASSERT) begin
      act_valid_next = 1'b1;
      act_idx_next   = win_idx;
    end else if (state == ASSERT && state_next != ASSERT) begin
      act_valid_next = 1'b0;
    end
  end

  assign INTR = intr_q;

  always_comb begin
    RD_DATA = 8'h00;
    if (RD_HIT) begin
      case (ofs)
        OFS_MASK:   RD_DATA = 8'(mask);
        OFS_PEND:   RD_DATA = 8'(pend);
        OFS_ACTIVE: RD_DATA = {act_valid, 4'b0000, act_idx};
        OFS_EDGE:   RD_DATA = 8'(edge_cfg);
        OFS_CTRL:   RD_DATA = {7'b0000000, gen};
        default:    RD_DATA = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed self-checking bench for rat_intr_ctrl: edge/level capture, priority,
// EOI gap, withdrawal, set-vs-clear collision and asynchronous reset.
module tb_rat_intr_ctrl;

  localparam logic [7:0] BASE = 8'hE0;

  logic       CLK, RESET_N, IO_STRB;
  logic [7:0] IRQ_IN, PORT_ID, OUT_PORT;
  logic [7:0] RD_DATA;
  logic       RD_HIT, INTR;

  int checks = 0;
  int errors = 0;

  rat_intr_ctrl #(.N_SRC(8), .BASE_ID(BASE)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IRQ_IN   (IRQ_IN),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .RD_DATA  (RD_DATA),
    .RD_HIT   (RD_HIT),
    .INTR     (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] irq);
    IRQ_IN = irq;
  endtask

  task automatic writeReg(input logic [7:0] ofs, input logic [7:0] data);
    PORT_ID  = BASE + ofs;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  task automatic readCheck(input logic [7:0] ofs, input logic [7:0] expected, input string tag);
    PORT_ID = BASE + ofs;
    #1;
    checkOutput(tag, RD_DATA, expected);
  endtask

  task automatic intrCheck(input logic expected, input string tag);
    checkOutput(tag, {7'b0, INTR}, {7'b0, expected});
  endtask

  initial begin
    RESET_N  = 1'b0;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    applyStimulus(8'h00);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    $display("[TB] reset defaults");
    intrCheck(1'b0, "rst_intr");
    readCheck(8'd0, 8'h00, "rst_mask");
    readCheck(8'd3, 8'hFF, "rst_edge");
    readCheck(8'd4, 8'h00, "rst_ctrl");

    $display("[TB] basic edge source");
    writeReg(8'd0, 8'h04);
    writeReg(8'd4, 8'h01);
    applyStimulus(8'h04);
    tick();
    applyStimulus(8'h00);
    tick();
    readCheck(8'd1, 8'h00, "basic_pend_early");
    tick();
    readCheck(8'd1, 8'h04, "basic_pend");
    intrCheck(1'b0, "basic_intr_early");
    tick();
    intrCheck(1'b1, "basic_intr");
    readCheck(8'd2, 8'h82, "basic_active");
    writeReg(8'd1, 8'h04);
    intrCheck(1'b1, "basic_intr_after_w1c");
    writeReg(8'd5, 8'h00);
    intrCheck(1'b0, "basic_gap");
    readCheck(8'd2, 8'h02, "basic_active_cleared");
    tick();
    intrCheck(1'b0, "basic_idle");
    tick();
    intrCheck(1'b0, "basic_stays_low");

    $display("[TB] priority and latch");
    writeReg(8'd0, 8'hFF);
    applyStimulus(8'h22);
    tick();
    tick();
    tick();
    readCheck(8'd1, 8'h22, "prio_pend");
    tick();
    intrCheck(1'b1, "prio_intr");
    readCheck(8'd2, 8'h81, "prio_active");
    applyStimulus(8'h23);
    tick();
    tick();
    tick();
    readCheck(8'd1, 8'h23, "prio_pend_bit0");
    readCheck(8'd2, 8'h81, "prio_active_held");
    writeReg(8'd1, 8'h02);
    writeReg(8'd5, 8'h00);
    intrCheck(1'b0, "prio_gap");
    tick();
    intrCheck(1'b0, "prio_idle");
    tick();
    intrCheck(1'b1, "prio_reassert");
    readCheck(8'd2, 8'h80, "prio_active_next");
    applyStimulus(8'h00);
    writeReg(8'd1, 8'hFF);
    writeReg(8'd5, 8'h00);
    tick();
    tick();
    tick();
    readCheck(8'd1, 8'h00, "prio_cleanup_pend");

    $display("[TB] withdrawal");
    applyStimulus(8'h08);
    tick();
    tick();
    tick();
    tick();
    intrCheck(1'b1, "wd_intr");
    readCheck(8'd2, 8'h83, "wd_active");
    writeReg(8'd0, 8'h00);
    intrCheck(1'b1, "wd_intr_same_edge");
    tick();
    intrCheck(1'b0, "wd_intr_dropped");
    readCheck(8'd2, 8'h03, "wd_active_invalid");
    readCheck(8'd1, 8'h08, "wd_pend_kept");
    applyStimulus(8'h00);
    writeReg(8'd1, 8'h08);
    tick();
    tick();

    $display("[TB] level source");
    writeReg(8'd3, 8'hFE);
    applyStimulus(8'h01);
    tick();
    tick();
    tick();
    readCheck(8'd1, 8'h01, "lvl_pend");
    writeReg(8'd1, 8'h01);
    readCheck(8'd1, 8'h01, "lvl_w1c_no_effect");
    tick();
    readCheck(8'd1, 8'h01, "lvl_still_set");
    applyStimulus(8'h00);
    tick();
    tick();
    writeReg(8'd1, 8'h01);
    readCheck(8'd1, 8'h00, "lvl_cleared");
    writeReg(8'd3, 8'hFF);

    $display("[TB] set vs clear collision and stray EOI");
    applyStimulus(8'h08);
    tick();
    tick();
    writeReg(8'd1, 8'h08);
    readCheck(8'd1, 8'h08, "col_set_wins");
    writeReg(8'd5, 8'h00);
    intrCheck(1'b0, "col_eoi_idle_intr");
    readCheck(8'd2, 8'h03, "col_eoi_idle_active");
    tick();
    intrCheck(1'b0, "col_idle_wait");
    writeReg(8'd0, 8'h08);
    intrCheck(1'b0, "col_mask_edge");
    tick();
    intrCheck(1'b1, "col_intr");
    readCheck(8'd2, 8'h83, "col_active");

    $display("[TB] asynchronous reset mid-assert");
    RESET_N = 1'b0;
    #1;
    intrCheck(1'b0, "ar_intr");
    readCheck(8'd2, 8'h00, "ar_active");
    readCheck(8'd0, 8'h00, "ar_mask");
    readCheck(8'd1, 8'h00, "ar_pend");
    readCheck(8'd3, 8'hFF, "ar_edge");
    readCheck(8'd4, 8'h00, "ar_ctrl");
    applyStimulus(8'h00);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    readCheck(8'd3, 8'hFF, "post_rst_edge");
    readCheck(8'd4, 8'h00, "post_rst_ctrl");
    intrCheck(1'b0, "post_rst_intr");
    readCheck(8'd5, 8'h00, "eoi_reads_zero");
    checkOutput("hit_eoi", {7'b0, RD_HIT}, 8'h01);
    PORT_ID = BASE + 8'd6;
    #1;
    checkOutput("miss_hit", {7'b0, RD_HIT}, 8'h00);
    checkOutput("miss_data", RD_DATA, 8'h00);
    PORT_ID = BASE - 8'd1;
    #1;
    checkOutput("miss_below", {7'b0, RD_HIT}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
